sys_arr_mac_seq: RTL and testbench

- Upstream sequencer for a single systolic-array MAC; it is the driving end of the MAC port protocol.
- Accepts a command, then streams DEPTH weights into the MAC shift chain with weight_en high.
- Then issues one start per input value and partial sum, waits for value_ready, and returns each out_accumulate on a valid/ready result port.
- Sits between the array tile controller/buffers and the MAC (or the head of one MAC column).

---
 rtl/sys_arr_pkg.sv | 16 +
 rtl/sys_arr_mac_seq_if.sv | 32 +++
 rtl/systolic_array_MAC_if.sv | 25 ++
 rtl/sys_arr_result_reg.sv | 27 ++
 rtl/sys_arr_mac_seq.sv | 158 +++++++++++++++
 tb/tb_sys_arr_mac_seq.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/sys_arr_pkg.sv
// Shared types and sizing for the systolic-array tile: data width plus the
// MAC sequencer's state encoding and default chain depth / wait budget.
package sys_arr_pkg;

    localparam int DW          = 16;
    localparam int SEQ_DEPTH   = 4;
    localparam int SEQ_TIMEOUT = 64;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_WLOAD,
        SEQ_STREAM,
        SEQ_WAIT
    } seq_state_t;

endpackage

// File: rtl/sys_arr_mac_seq_if.sv
// Tile-controller side of the MAC sequencer: command, weight, input and result
// valid/ready channels plus done/err status.
interface sys_arr_mac_seq_if #(
    parameter int DW    = sys_arr_pkg::DW,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_num_inputs;
    logic             w_valid;
    logic             w_ready;
    logic [DW-1:0]    w_data;
    logic             x_valid;
    logic             x_ready;
    logic [DW-1:0]    x_data;
    logic [DW-1:0]    x_psum;
    logic             r_valid;
    logic             r_ready;
    logic [DW-1:0]    r_data;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_num_inputs, w_valid, w_data, x_valid, x_data, x_psum, r_ready,
        input  cmd_ready, w_ready, x_ready, r_valid, r_data, done, err
    );

    modport slave (
        input  cmd_valid, cmd_num_inputs, w_valid, w_data, x_valid, x_data, x_psum, r_ready,
        output cmd_ready, w_ready, x_ready, r_valid, r_data, done, err
    );
endinterface

// File: rtl/systolic_array_MAC_if.sv
// Port bundle between one systolic-array MAC and whatever drives it; the
// array modport is the driving end, the mac modport is the MAC itself.
interface systolic_array_MAC_if #(
    parameter int DW = sys_arr_pkg::DW
);
    logic          start;
    logic [DW-1:0] in_value;
    logic          MAC_shift;
    logic [DW-1:0] in_accumulate;
    logic          weight_en;
    logic [DW-1:0] out_accumulate;
    logic          value_ready;
    logic [DW-1:0] in_pass;
    logic          weight_next_en;

    modport mac (
        input  start, in_value, MAC_shift, in_accumulate, weight_en,
        output out_accumulate, value_ready, in_pass, weight_next_en
    );

    modport array (
        output start, in_value, MAC_shift, in_accumulate, weight_en,
        input  out_accumulate, value_ready, in_pass, weight_next_en
    );
endinterface

// File: rtl/sys_arr_result_reg.sv
// Single-entry valid/ready holding register for MAC results; a capture wins
// over a same-cycle drain so the new word is kept.
module sys_arr_result_reg #(
    parameter int DW = sys_arr_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture,
    input  logic [DW-1:0] cap_data,
    input  logic          r_ready,
    output logic          r_valid,
    output logic [DW-1:0] r_data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (capture) begin
            r_valid <= 1'b1;
            r_data  <= cap_data;
        end else if (r_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sys_arr_mac_seq.sv
// Upstream sequencer for one systolic-array MAC: loads DEPTH weights into the
// shift chain, then streams inputs one start at a time and returns each result.
module sys_arr_mac_seq
    import sys_arr_pkg::*;
#(
    parameter int DW      = sys_arr_pkg::DW,
    parameter int DEPTH   = SEQ_DEPTH,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = SEQ_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    sys_arr_mac_seq_if.slave     host,
    systolic_array_MAC_if.array  mac
);

    localparam int WCNT_W = $clog2(DEPTH + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [CNT_W-1:0]  icnt;
    logic [WCNT_W-1:0] wcnt;
    logic [TCNT_W-1:0] tcnt;
    logic [DW-1:0]     value_q;
    logic [DW-1:0]     acc_q;
    logic              start_q;
    logic              done_q;
    logic              err_q;

    logic              cmd_ready_c;
    logic              w_ready_c;
    logic              x_ready_c;
    logic              weight_en_c;
    logic              shift_c;
    logic [DW-1:0]     value_bus;
    logic              x_fire;
    logic              last_weight;
    logic              capture;
    logic              timeout_hit;

    // The start cycle is the first WAIT cycle, so start_q doubles as the
    // "ignore value_ready now" marker.
    assign capture     = (state == SEQ_WAIT) && !start_q && mac.value_ready;
    assign timeout_hit = (state == SEQ_WAIT) && !capture && (tcnt == TCNT_W'(TIMEOUT - 1));
    assign x_fire      = x_ready_c && host.x_valid;
    assign last_weight = shift_c && (wcnt == WCNT_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEQ_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        cmd_ready_c = 1'b0;
        w_ready_c   = 1'b0;
        x_ready_c   = 1'b0;
        weight_en_c = 1'b0;
        shift_c     = 1'b0;
        value_bus   = value_q;
        case (state)
            SEQ_IDLE: begin
                cmd_ready_c = 1'b1;
                if (host.cmd_valid) begin
                    next_state = SEQ_WLOAD;
                end
            end
            SEQ_WLOAD: begin
                weight_en_c = 1'b1;
                w_ready_c   = 1'b1;
                if (host.w_valid) begin
                    shift_c   = 1'b1;
                    value_bus = host.w_data;
                    if (wcnt == WCNT_W'(DEPTH - 1)) begin
                        next_state = (icnt != '0) ? SEQ_STREAM : SEQ_IDLE;
                    end
                end
            end
            SEQ_STREAM: begin
                // Only accept an input if its result will have somewhere to land.
                x_ready_c = !host.r_valid || host.r_ready;
                if (host.x_valid && x_ready_c) begin
                    next_state = SEQ_WAIT;
                end
            end
            SEQ_WAIT: begin
                if (capture) begin
                    next_state = (icnt == CNT_W'(1)) ? SEQ_IDLE : SEQ_STREAM;
                end else if (timeout_hit) begin
                    next_state = SEQ_IDLE;
                end
            end
            default: next_state = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icnt    <= '0;
            wcnt    <= '0;
            tcnt    <= '0;
            value_q <= '0;
            acc_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            start_q <= x_fire;
            done_q  <= (last_weight && (icnt == '0)) || (capture && (icnt == CNT_W'(1)));
            if ((state == SEQ_IDLE) && host.cmd_valid) begin
                icnt <= host.cmd_num_inputs;
                wcnt <= '0;
            end else if (capture) begin
                icnt <= icnt - CNT_W'(1);
            end
            if (shift_c) begin
                wcnt    <= wcnt + WCNT_W'(1);
                value_q <= host.w_data;
            end
            if (x_fire) begin
                value_q <= host.x_data;
                acc_q   <= host.x_psum;
                tcnt    <= '0;
            end else if (state == SEQ_WAIT) begin
                tcnt <= tcnt + TCNT_W'(1);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    sys_arr_result_reg #(.DW(DW)) u_result (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .cap_data (mac.out_accumulate),
        .r_ready  (host.r_ready),
        .r_valid  (host.r_valid),
        .r_data   (host.r_data)
    );

    assign host.cmd_ready    = cmd_ready_c;
    assign host.w_ready      = w_ready_c;
    assign host.x_ready      = x_ready_c;
    assign host.done         = done_q;
    assign host.err          = err_q;
    assign mac.start         = start_q;
    assign mac.in_value      = value_bus;
    assign mac.MAC_shift     = shift_c;
    assign mac.in_accumulate = acc_q;
    assign mac.weight_en     = weight_en_c;

endmodule

// File: tb/tb_sys_arr_mac_seq.sv
// Bench for sys_arr_mac_seq: a behavioural MAC answers start pulses, and each
// scenario task checks handshakes, timing and results against its own model.
module tb_sys_arr_mac_seq;

    localparam int DW      = 16;
    localparam int CNT_W   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   cyc;
    int   rr_mode;
    bit   mac_dead;

    sys_arr_mac_seq_if #(.DW(DW), .CNT_W(CNT_W)) host_if ();
    systolic_array_MAC_if #(.DW(DW)) mac_if ();

    sys_arr_mac_seq #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (host_if),
        .mac  (mac_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       host_if.r_ready = 1'b0;
            1:       host_if.r_ready = 1'b1;
            default: host_if.r_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Behavioural MAC: the first weight shifted in ends at the far end of the
    // chain and is the one multiplied; value_ready rises two cycles after start.
    logic [DEPTH-1:0][DW-1:0] wreg;
    logic                     vr;
    logic                     pend;
    logic [DW-1:0]            oacc;

    always @(posedge clk) begin
        if (rst) begin
            vr   <= 1'b0;
            pend <= 1'b0;
        end else begin
            if (mac_if.MAC_shift) wreg <= {wreg[DEPTH-2:0], mac_if.in_value};
            if (mac_if.start) begin
                pend <= 1'b1;
                vr   <= 1'b0;
                oacc <= DW'(mac_if.in_accumulate + mac_if.in_value * wreg[DEPTH-1]);
            end else if (pend && !mac_dead) begin
                pend <= 1'b0;
                vr   <= 1'b1;
            end
        end
    end

    assign mac_if.value_ready    = vr;
    assign mac_if.out_accumulate = oacc;
    assign mac_if.in_pass        = '0;
    assign mac_if.weight_next_en = 1'b0;

    logic [DW-1:0] shift_q[$];
    logic [DW-1:0] res_q[$];
    int start_cnt, done_cnt, wen_cnt, shift_hs_err;
    int last_shift_cyc, done_cyc, start_cyc, err_cyc, rv_rise_cyc;
    logic prev_rv, prev_err;

    initial begin
        start_cnt = 0; done_cnt = 0; wen_cnt = 0; shift_hs_err = 0;
        last_shift_cyc = 0; done_cyc = 0; start_cyc = 0; err_cyc = 0; rv_rise_cyc = 0;
        prev_rv = 1'b0; prev_err = 1'b0;
    end

    always @(negedge clk) begin
        if (mac_if.MAC_shift === 1'b1) begin
            shift_q.push_back(mac_if.in_value);
            last_shift_cyc <= cyc;
        end
        if (mac_if.MAC_shift !== (host_if.w_valid && host_if.w_ready)) shift_hs_err <= shift_hs_err + 1;
        if (mac_if.start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (host_if.done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (mac_if.weight_en === 1'b1) wen_cnt <= wen_cnt + 1;
        if (host_if.r_valid === 1'b1 && host_if.r_ready === 1'b1) res_q.push_back(host_if.r_data);
        if (host_if.r_valid === 1'b1 && !prev_rv) rv_rise_cyc <= cyc;
        if (host_if.err === 1'b1 && !prev_err) err_cyc <= cyc;
        prev_rv  <= host_if.r_valid;
        prev_err <= host_if.err;
    end

    // Drivers: every task starts and ends 1 time unit after a rising edge.
    task automatic issue_cmd(input int n);
        bit ok = 1'b0;
        host_if.cmd_valid      = 1'b1;
        host_if.cmd_num_inputs = CNT_W'(n);
        for (int i = 0; i < 100 && !ok; i++) begin
            #1 ok = host_if.cmd_ready;
            @(posedge clk); #1;
        end
        host_if.cmd_valid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("[TB] FAIL cmd_accept: cmd_ready stayed 0, expected 1 within 100 cycles");
        end
    endtask

    task automatic send_weight(input logic [DW-1:0] w, input bit gap);
        bit ok = 1'b0;
        if (gap) begin host_if.w_valid = 1'b0; @(posedge clk); #1; end
        host_if.w_valid = 1'b1;
        host_if.w_data  = w;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1 ok = host_if.w_ready;
            @(posedge clk); #1;
        end
        host_if.w_valid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("[TB] FAIL w_accept: w_ready stayed 0, expected 1 within 100 cycles");
        end
    endtask

    task automatic send_x(input logic [DW-1:0] x, input logic [DW-1:0] p, input bit gap);
        bit ok = 1'b0;
        if (gap) begin host_if.x_valid = 1'b0; @(posedge clk); #1; end
        host_if.x_valid = 1'b1;
        host_if.x_data  = x;
        host_if.x_psum  = p;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1 ok = host_if.x_ready;
            @(posedge clk); #1;
        end
        host_if.x_valid = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("[TB] FAIL x_accept: x_ready stayed 0, expected 1 within 200 cycles");
        end
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 300 && done_cnt <= base; i++) begin
            @(posedge clk); #1;
        end
        if (done_cnt <= base) begin
            vectors++; miscompares++;
            $display("[TB] FAIL done_wait: done count %0d, expected > %0d", done_cnt, base);
        end
    endtask

    task automatic load_weights_1to4();
        for (int k = 0; k < DEPTH; k++) send_weight(DW'(k + 1), 1'b0);
    endtask

    task automatic test_reset();
        logic [10:0] outs;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        outs = {host_if.w_ready, host_if.x_ready, host_if.r_valid, host_if.done, host_if.err,
                mac_if.start, mac_if.weight_en, mac_if.MAC_shift, |mac_if.in_value,
                |mac_if.in_accumulate, |host_if.r_data};
        vectors++;
        if (host_if.cmd_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", host_if.cmd_ready);
        end
        vectors++;
        if (outs !== 11'b0) begin
            miscompares++; $display("[TB] FAIL reset_outputs: got %b expected all 0", outs);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_weight_only();
        int sb = shift_q.size(), stb = start_cnt, wb = wen_cnt, db = done_cnt;
        issue_cmd(0);
        load_weights_1to4();
        wait_done(db);
        vectors++;
        if (shift_q.size() - sb != DEPTH) begin
            miscompares++; $display("[TB] FAIL wonly_shift_count: got %0d expected %0d", shift_q.size() - sb, DEPTH);
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                vectors++;
                if (shift_q[sb + k] !== DW'(k + 1)) begin
                    miscompares++; $display("[TB] FAIL wonly_in_value[%0d]: got %h expected %h", k, shift_q[sb + k], DW'(k + 1));
                end
            end
        end
        vectors++;
        if (wen_cnt - wb != DEPTH) begin
            miscompares++; $display("[TB] FAIL wonly_weight_en_cycles: got %0d expected %0d", wen_cnt - wb, DEPTH);
        end
        vectors++;
        if (done_cyc != last_shift_cyc + 1) begin
            miscompares++; $display("[TB] FAIL wonly_done_timing: done at %0d expected %0d", done_cyc, last_shift_cyc + 1);
        end
        vectors++;
        if (start_cnt != stb) begin
            miscompares++; $display("[TB] FAIL wonly_no_start: got %0d starts expected 0", start_cnt - stb);
        end
    endtask

    task automatic test_stream_basic();
        int rb = res_q.size(), stb = start_cnt, db = done_cnt;
        logic [DW-1:0] exp_r[2] = '{16'h0013, 16'h0025};
        rr_mode = 1;
        issue_cmd(2);
        load_weights_1to4();
        send_x(16'h0003, 16'h0010, 1'b0);
        send_x(16'h0005, 16'h0020, 1'b0);
        wait_done(db);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (res_q.size() - rb != 2) begin
            miscompares++; $display("[TB] FAIL stream_result_count: got %0d expected 2", res_q.size() - rb);
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (res_q[rb + i] !== exp_r[i]) begin
                    miscompares++; $display("[TB] FAIL stream_r_data[%0d]: got %h expected %h", i, res_q[rb + i], exp_r[i]);
                end
            end
        end
        vectors++;
        if (start_cnt - stb != 2) begin
            miscompares++; $display("[TB] FAIL stream_start_count: got %0d expected 2", start_cnt - stb);
        end
        vectors++;
        if (done_cyc != rv_rise_cyc) begin
            miscompares++; $display("[TB] FAIL stream_done_timing: done at %0d expected %0d", done_cyc, rv_rise_cyc);
        end
    endtask

    task automatic test_backpressure();
        int rb = res_q.size(), stb, db = done_cnt, blocked = 0;
        rr_mode = 0;
        issue_cmd(2);
        load_weights_1to4();
        send_x(16'h0003, 16'h0010, 1'b0);
        for (int i = 0; i < 50 && host_if.r_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        stb = start_cnt;
        host_if.x_valid = 1'b1;
        host_if.x_data  = 16'h0005;
        host_if.x_psum  = 16'h0020;
        for (int i = 0; i < 6; i++) begin
            #1 if (host_if.x_ready !== 1'b0) blocked++;
            @(posedge clk); #1;
        end
        vectors++;
        if (blocked != 0) begin
            miscompares++; $display("[TB] FAIL bp_x_ready: x_ready high in %0d cycles expected 0", blocked);
        end
        vectors++;
        if (start_cnt != stb) begin
            miscompares++; $display("[TB] FAIL bp_no_start: got %0d extra starts expected 0", start_cnt - stb);
        end
        vectors++;
        if (host_if.r_valid !== 1'b1 || host_if.r_data !== 16'h0013) begin
            miscompares++; $display("[TB] FAIL bp_r_hold: got valid=%b data=%h expected 1/0013", host_if.r_valid, host_if.r_data);
        end
        rr_mode = 1;
        send_x(16'h0005, 16'h0020, 1'b0);
        wait_done(db);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (res_q.size() - rb != 2 || res_q[rb] !== 16'h0013 || res_q[rb + 1] !== 16'h0025) begin
            miscompares++; $display("[TB] FAIL bp_results: got %0d results expected 2 (0013, 0025)", res_q.size() - rb);
        end
    endtask

    task automatic test_w_toggle();
        int sb = shift_q.size(), wb = wen_cnt, hb = shift_hs_err, db = done_cnt;
        issue_cmd(0);
        for (int k = 0; k < DEPTH; k++) send_weight(DW'(16'h0A0 + k), k != 0);
        wait_done(db);
        vectors++;
        if (shift_hs_err != hb) begin
            miscompares++; $display("[TB] FAIL toggle_shift_vs_hs: %0d cycles differ expected 0", shift_hs_err - hb);
        end
        vectors++;
        if (shift_q.size() - sb != DEPTH || shift_q[shift_q.size() - 1] !== 16'h0A3) begin
            miscompares++; $display("[TB] FAIL toggle_shift_count: got %0d shifts expected %0d", shift_q.size() - sb, DEPTH);
        end
        vectors++;
        if (wen_cnt - wb != 2 * DEPTH - 1) begin
            miscompares++; $display("[TB] FAIL toggle_weight_en: got %0d cycles expected %0d", wen_cnt - wb, 2 * DEPTH - 1);
        end
    endtask

    task automatic test_timeout();
        int db = done_cnt;
        mac_dead = 1'b1;
        rr_mode  = 1;
        issue_cmd(1);
        load_weights_1to4();
        send_x(16'h0007, 16'h0001, 1'b0);
        for (int i = 0; i < 150 && host_if.err !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        vectors++;
        if (host_if.err !== 1'b1 || err_cyc - start_cyc != TIMEOUT) begin
            miscompares++; $display("[TB] FAIL timeout_err: err=%b after %0d cycles expected 1 after %0d", host_if.err, err_cyc - start_cyc, TIMEOUT);
        end
        vectors++;
        if (host_if.cmd_ready !== 1'b1 || done_cnt != db || host_if.r_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL timeout_idle: cmd_ready=%b dones=%0d r_valid=%b expected 1/0/0", host_if.cmd_ready, done_cnt - db, host_if.r_valid);
        end
        issue_cmd(0);
        load_weights_1to4();
        wait_done(done_cnt);
        vectors++;
        if (host_if.err !== 1'b1) begin
            miscompares++; $display("[TB] FAIL timeout_sticky: err=%b expected 1", host_if.err);
        end
    endtask

    task automatic test_reset_mid_wait();
        int stb = start_cnt;
        logic [4:0] obs;
        mac_dead = 1'b1;
        issue_cmd(1);
        load_weights_1to4();
        send_x(16'h0009, 16'h0002, 1'b0);
        for (int i = 0; i < 20 && start_cnt == stb; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 obs = {mac_if.start, mac_if.weight_en, host_if.cmd_ready, host_if.err, host_if.r_valid};
        vectors++;
        if (obs !== 5'b00100) begin
            miscompares++; $display("[TB] FAIL rst_mid_wait: start/wen/cmd_ready/err/r_valid=%b expected 00100", obs);
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        mac_dead = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] w0, wv, x, p;
        int n, total = 0, rb = res_q.size(), db = done_cnt;
        int ncmd = 6;
        w0 = '0;
        rr_mode = 2;
        for (int c = 0; c < ncmd; c++) begin
            n = $urandom_range(1, 4);
            issue_cmd(n);
            for (int k = 0; k < DEPTH; k++) begin
                wv = DW'($urandom);
                if (k == 0) w0 = wv;
                send_weight(wv, 1'($urandom_range(0, 1)));
            end
            for (int j = 0; j < n; j++) begin
                x = DW'($urandom);
                p = DW'($urandom);
                exp_q.push_back(DW'(p + x * w0));
                send_x(x, p, 1'($urandom_range(0, 1)));
            end
            total += n;
            wait_done(db + c);
        end
        rr_mode = 1;
        for (int i = 0; i < 50 && res_q.size() - rb < total; i++) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (res_q.size() - rb != total) begin
            miscompares++; $display("[TB] FAIL rand_result_count: got %0d expected %0d", res_q.size() - rb, total);
        end else begin
            for (int i = 0; i < total; i++) begin
                vectors++;
                if (res_q[rb + i] !== exp_q[i]) begin
                    miscompares++; $display("[TB] FAIL rand_r_data[%0d]: got %h expected %h", i, res_q[rb + i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (done_cnt - db != ncmd) begin
            miscompares++; $display("[TB] FAIL rand_done_count: got %0d expected %0d", done_cnt - db, ncmd);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rr_mode     = 1;
        mac_dead    = 1'b0;
        rst         = 1'b1;
        host_if.cmd_valid      = 1'b0;
        host_if.cmd_num_inputs = '0;
        host_if.w_valid        = 1'b0;
        host_if.w_data         = '0;
        host_if.x_valid        = 1'b0;
        host_if.x_data         = '0;
        host_if.x_psum         = '0;
        test_reset();
        test_weight_only();
        test_stream_basic();
        test_backpressure();
        test_w_toggle();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
